pc_fetch_sequencer: RTL and testbench

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_fetch_sequencer_if.sv | 36 +++
 rtl/next_pc_calc.sv | 26 ++
 rtl/pc_fetch_sequencer.sv | 102 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Holds the sequencer state set, default address width, instruction width and PC step.
package pc_seq_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC  = 4;

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StExec  = 2'b01,
        StError = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory, datapath and status signals of the PC fetch sequencer.
// The master modport is the sequencer; the slave modport is memory plus datapath.
interface pc_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = pc_seq_pkg::ADDR_W
);

    logic [ADDR_W-1:0]              StartPC;
    logic                           IMemReq;
    logic [ADDR_W-1:0]              IMemAddr;
    logic                           IMemAck;
    logic [pc_seq_pkg::INSTR_W-1:0] Instr;
    logic [pc_seq_pkg::INSTR_W-1:0] InstrOut;
    logic                           InstrValid;
    logic                           ExecDone;
    logic                           Branch;
    logic                           Uncondbranch;
    logic                           ALUZero;
    logic [ADDR_W-1:0]              SignExtImm64;
    logic                           Stall;
    logic [ADDR_W-1:0]              CurrentPC;
    logic [31:0]                    RetireCount;
    logic                           FetchErr;

    modport master (
        input  StartPC, IMemAck, Instr, ExecDone, Branch, Uncondbranch, ALUZero,
               SignExtImm64, Stall,
        output IMemReq, IMemAddr, InstrOut, InstrValid, CurrentPC, RetireCount, FetchErr
    );

    modport slave (
        output StartPC, IMemAck, Instr, ExecDone, Branch, Uncondbranch, ALUZero,
               SignExtImm64, Stall,
        input  IMemReq, IMemAddr, InstrOut, InstrValid, CurrentPC, RetireCount, FetchErr
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC: word-scaled branch offset when taken, else sequential step.
// Arithmetic wraps modulo 2^ADDR_W; result stays word aligned.
module next_pc_calc #(
    parameter int unsigned ADDR_W = pc_seq_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] imm_i,
    input  logic              branch_i,
    input  logic              uncond_i,
    input  logic              alu_zero_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    import pc_seq_pkg::*;

    logic              take;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] sum;

    always_comb begin
        take      = uncond_i | (branch_i & alu_zero_i);
        offset    = take ? (imm_i << 2) : ADDR_W'(PC_INC);
        sum       = pc_i + offset;
        next_pc_o = sum & ~ADDR_W'(3);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer: requests an instruction at CurrentPC, holds it for the
// datapath, then advances the PC; a fetch that never gets acknowledged locks up in error.
module pc_fetch_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned ADDR_W  = pc_seq_pkg::ADDR_W
) (
    input logic                 CLK,
    input logic                 Reset_L,
    pc_fetch_sequencer_if.master bus
);
    import pc_seq_pkg::*;

    localparam int unsigned       CntW     = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]   WaitLast = CntW'(TIMEOUT - 1);

    seq_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [31:0]          retire_q, retire_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0]    next_pc;

    next_pc_calc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc (
        .pc_i       (pc_q),
        .imm_i      (bus.SignExtImm64),
        .branch_i   (bus.Branch),
        .uncond_i   (bus.Uncondbranch),
        .alu_zero_i (bus.ALUZero),
        .next_pc_o  (next_pc)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q     <= StFetch;
            pc_q        <= bus.StartPC & ~ADDR_W'(3);
            wait_cnt_q  <= '0;
            retire_q    <= '0;
            instr_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_cnt_q  <= wait_cnt_d;
            retire_q    <= retire_d;
            instr_q     <= instr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_cnt_d  = wait_cnt_q;
        retire_d    = retire_q;
        instr_d     = instr_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            StFetch: begin
                // An ack in the last allowed wait cycle still wins over the timeout.
                if (bus.IMemAck) begin
                    instr_d    = bus.Instr;
                    state_d    = StExec;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WaitLast) begin
                    state_d     = StError;
                    fetch_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StExec: begin
                if (bus.ExecDone && !bus.Stall) begin
                    pc_d       = next_pc;
                    retire_d   = retire_q + 32'd1;
                    state_d    = StFetch;
                    wait_cnt_d = '0;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d     = StError;
                fetch_err_d = 1'b1;
            end
        endcase
    end

    // Handshakes are forced low while reset is held so nothing escapes before release.
    assign bus.IMemReq     = Reset_L && (state_q == StFetch);
    assign bus.InstrValid  = Reset_L && (state_q == StExec);
    assign bus.IMemAddr    = pc_q;
    assign bus.CurrentPC   = pc_q;
    assign bus.InstrOut    = instr_q;
    assign bus.RetireCount = retire_q;
    assign bus.FetchErr    = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed table, hand-written corner sequences and
// a randomized run against a transaction-level model of the fetch/execute rules.
module tb_pc_fetch_sequencer;

    localparam int unsigned TO = 15;

    logic CLK;
    logic Reset_L;
    int   total;
    int   bad;

    pc_fetch_sequencer_if #(.ADDR_W(64)) bus ();

    pc_fetch_sequencer #(
        .TIMEOUT (TO),
        .ADDR_W  (64)
    ) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ack;
        logic [31:0] instr;
        logic        done;
        logic        br;
        logic        ub;
        logic        zero;
        logic        stall;
        logic [63:0] imm;
        logic        exp_req;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_ret;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl[$];

    // Model state: what the sequencer should be doing, in transaction terms.
    logic [63:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_instr;
    logic        m_err;
    bit          m_waiting_mem;
    bit          m_executing;
    int          m_waited;

    function automatic vec_t mk(logic ack, logic [31:0] instr, logic done, logic br,
                                logic ub, logic zero, logic stall, logic [63:0] imm,
                                logic exp_req, logic exp_valid, logic [63:0] exp_pc,
                                logic [31:0] exp_ret, logic [31:0] exp_instr);
        vec_t v;
        v.ack = ack; v.instr = instr; v.done = done; v.br = br; v.ub = ub;
        v.zero = zero; v.stall = stall; v.imm = imm; v.exp_req = exp_req;
        v.exp_valid = exp_valid; v.exp_pc = exp_pc; v.exp_ret = exp_ret;
        v.exp_instr = exp_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IMemAck = 0; bus.Instr = '0; bus.ExecDone = 0; bus.Branch = 0;
        bus.Uncondbranch = 0; bus.ALUZero = 0; bus.Stall = 0; bus.SignExtImm64 = '0;
    endtask

    task automatic do_reset(input logic [63:0] start);
        Reset_L = 0;
        bus.StartPC = start;
        tick();
        tick();
        Reset_L = 1;
    endtask

    task automatic model_edge();
        if (!Reset_L) begin
            m_pc = bus.StartPC & ~64'd3;
            m_ret = 0; m_instr = 0; m_err = 0;
            m_waiting_mem = 1; m_executing = 0; m_waited = 0;
        end else if (m_waiting_mem) begin
            if (bus.IMemAck) begin
                m_instr = bus.Instr;
                m_waiting_mem = 0;
                m_executing = 1;
                m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_waiting_mem = 0;
                    m_err = 1;
                end
            end
        end else if (m_executing && bus.ExecDone && !bus.Stall) begin
            if (bus.Uncondbranch || (bus.Branch && bus.ALUZero))
                m_pc = m_pc + bus.SignExtImm64 * 64'd4;
            else
                m_pc = m_pc + 64'd4;
            m_ret = m_ret + 1;
            m_executing = 0;
            m_waiting_mem = 1;
            m_waited = 0;
        end
    endtask

    task automatic model_check();
        chk("rnd_req",   {63'd0, bus.IMemReq},    {63'd0, Reset_L && m_waiting_mem});
        chk("rnd_valid", {63'd0, bus.InstrValid}, {63'd0, Reset_L && m_executing});
        chk("rnd_addr",  bus.IMemAddr,            m_pc);
        chk("rnd_pc",    bus.CurrentPC,           m_pc);
        chk("rnd_ret",   {32'd0, bus.RetireCount}, {32'd0, m_ret});
        chk("rnd_instr", {32'd0, bus.InstrOut},   {32'd0, m_instr});
        chk("rnd_err",   {63'd0, bus.FetchErr},   {63'd0, m_err});
    endtask

    initial begin
        total = 0;
        bad = 0;
        idle_inputs();
        Reset_L = 0;
        bus.StartPC = '0;

        // Reset vector low bits dropped, no handshakes while held, ack two cycles later.
        do_reset(64'h1003);
        chk("rst_pc", bus.CurrentPC, 64'h1000);
        chk("rst_ret", {32'd0, bus.RetireCount}, 64'd0);
        chk("rst_instr", {32'd0, bus.InstrOut}, 64'd0);
        chk("rst_err", {63'd0, bus.FetchErr}, 64'd0);
        Reset_L = 0;
        tick();
        chk("rst_req_low", {63'd0, bus.IMemReq}, 64'd0);
        chk("rst_valid_low", {63'd0, bus.InstrValid}, 64'd0);
        Reset_L = 1;
        #1;
        chk("first_req", {63'd0, bus.IMemReq}, 64'd1);
        tick();
        chk("wait_addr", bus.IMemAddr, 64'h1000);
        bus.IMemAck = 1; bus.Instr = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("ack_valid", {63'd0, bus.InstrValid}, 64'd1);
        chk("ack_req", {63'd0, bus.IMemReq}, 64'd0);
        chk("ack_instr", {32'd0, bus.InstrOut}, 64'hDEAD_BEEF);
        bus.ExecDone = 1;
        tick();
        idle_inputs();
        chk("seq_addr", bus.IMemAddr, 64'h1004);
        chk("seq_ret", {32'd0, bus.RetireCount}, 64'd1);
        chk("seq_req", {63'd0, bus.IMemReq}, 64'd1);

        // Directed table from PC 0x1000.
        tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,    1, 0, 64'h1000, 0, 0));
        tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0, 0,    1, 0, 64'h1000, 0, 0));
        tbl.push_back(mk(1, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1000, 0, 32'hAAAA0001));
        tbl.push_back(mk(1, 32'hBBBB0002, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1000, 0, 32'hAAAA0001));
        tbl.push_back(mk(0, 0,   1, 0, 1, 0, 0, -64'sd2, 1, 0, 64'h0FF8, 1, 32'hAAAA0001));
        tbl.push_back(mk(1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0FF8, 1, 32'h22));
        tbl.push_back(mk(0, 0,   1, 1, 0, 0, 0, -64'sd2, 1, 0, 64'h0FFC, 2, 32'h22));
        tbl.push_back(mk(1, 32'h33, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0FFC, 2, 32'h33));
        tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 64'd3, 1, 0, 64'h1008, 3, 32'h33));
        tbl.push_back(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1008, 3, 32'h44));
        tbl.push_back(mk(0, 0,   1, 0, 1, 0, 1, 64'd5, 0, 1, 64'h1008, 3, 32'h44));
        tbl.push_back(mk(0, 0,   1, 0, 1, 0, 1, 64'd5, 0, 1, 64'h1008, 3, 32'h44));
        tbl.push_back(mk(0, 0,   1, 0, 1, 0, 1, 64'd5, 0, 1, 64'h1008, 3, 32'h44));
        tbl.push_back(mk(0, 0,   1, 0, 1, 0, 0, 64'd5, 1, 0, 64'h101C, 4, 32'h44));
        tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0, 0,    1, 0, 64'h101C, 4, 32'h44));

        do_reset(64'h1000);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.IMemAck = tbl[i].ack; bus.Instr = tbl[i].instr; bus.ExecDone = tbl[i].done;
            bus.Branch = tbl[i].br; bus.Uncondbranch = tbl[i].ub; bus.ALUZero = tbl[i].zero;
            bus.Stall = tbl[i].stall; bus.SignExtImm64 = tbl[i].imm;
            tick();
            chk($sformatf("tbl%0d_req", i), {63'd0, bus.IMemReq}, {63'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_valid", i), {63'd0, bus.InstrValid},
                {63'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_pc", i), bus.IMemAddr, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_ret", i), {32'd0, bus.RetireCount}, {32'd0, tbl[i].exp_ret});
            chk($sformatf("tbl%0d_instr", i), {32'd0, bus.InstrOut},
                {32'd0, tbl[i].exp_instr});
        end
        idle_inputs();

        // PC wraps silently at the top of the address space.
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        bus.IMemAck = 1;
        tick();
        idle_inputs();
        bus.ExecDone = 1;
        tick();
        idle_inputs();
        chk("wrap_pc", bus.CurrentPC, 64'h0);
        chk("wrap_err", {63'd0, bus.FetchErr}, 64'd0);

        // Fifteen unacknowledged fetch cycles lock into error; PC and count frozen.
        do_reset(64'h3000);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        chk("to_pre_err", {63'd0, bus.FetchErr}, 64'd0);
        chk("to_pre_req", {63'd0, bus.IMemReq}, 64'd1);
        tick();
        chk("to_err", {63'd0, bus.FetchErr}, 64'd1);
        chk("to_req", {63'd0, bus.IMemReq}, 64'd0);
        chk("to_valid", {63'd0, bus.InstrValid}, 64'd0);
        bus.IMemAck = 1; bus.ExecDone = 1; bus.Uncondbranch = 1; bus.SignExtImm64 = 64'd8;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        chk("to_hold_err", {63'd0, bus.FetchErr}, 64'd1);
        chk("to_hold_req", {63'd0, bus.IMemReq}, 64'd0);
        chk("to_hold_pc", bus.CurrentPC, 64'h3000);
        chk("to_hold_ret", {32'd0, bus.RetireCount}, 64'd0);

        // Ack arriving in the final allowed cycle still succeeds.
        do_reset(64'h3000);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        bus.IMemAck = 1; bus.Instr = 32'h1234_5678;
        tick();
        idle_inputs();
        chk("to_last_valid", {63'd0, bus.InstrValid}, 64'd1);
        chk("to_last_err", {63'd0, bus.FetchErr}, 64'd0);
        chk("to_last_instr", {32'd0, bus.InstrOut}, 64'h1234_5678);

        // Reset in the middle of execution, then a late ack counts as a fresh one.
        bus.ExecDone = 1;
        tick();
        idle_inputs();
        bus.IMemAck = 1;
        tick();
        chk("mid_valid", {63'd0, bus.InstrValid}, 64'd1);
        Reset_L = 0; bus.StartPC = 64'h2000;
        tick();
        chk("mid_rst_pc", bus.CurrentPC, 64'h2000);
        chk("mid_rst_ret", {32'd0, bus.RetireCount}, 64'd0);
        chk("mid_rst_req", {63'd0, bus.IMemReq}, 64'd0);
        chk("mid_rst_valid", {63'd0, bus.InstrValid}, 64'd0);
        Reset_L = 1;
        #1;
        chk("mid_rel_req", {63'd0, bus.IMemReq}, 64'd1);
        tick();
        idle_inputs();
        chk("mid_late_ack", {63'd0, bus.InstrValid}, 64'd1);

        // Randomized traffic against the model, with occasional resets.
        Reset_L = 0;
        bus.StartPC = {$urandom, $urandom};
        model_edge();
        tick();
        for (int c = 0; c < 3000; c++) begin
            int s;
            Reset_L = ($urandom_range(0, 59) != 0);
            bus.StartPC = (c % 7 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom};
            bus.IMemAck = ($urandom_range(0, 3) == 0);
            bus.Instr = $urandom;
            bus.ExecDone = $urandom_range(0, 1);
            bus.Branch = $urandom_range(0, 1);
            bus.Uncondbranch = ($urandom_range(0, 3) == 0);
            bus.ALUZero = $urandom_range(0, 1);
            bus.Stall = ($urandom_range(0, 2) == 0);
            s = int'($urandom_range(0, 64)) - 32;
            bus.SignExtImm64 = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                           : {{32{s[31]}}, s};
            model_edge();
            tick();
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
